// File: rtl/intr_pkg.sv
// intr_pkg: shared state encodings and source count for the interrupt controller.
package intr_pkg;
  localparam int NSRC = 8;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;
endpackage

// File: rtl/intr_ctrl8_if.sv
// intr_ctrl8_if: CPU-facing signal bundle; master is the CPU side, slave is the controller.
interface intr_ctrl8_if;
  import intr_pkg::*;
  logic [NSRC-1:0] irq_in;
  logic            mask_we;
  logic [NSRC-1:0] mask_in;
  logic            irq_ack;
  logic            eoi;
  logic            irq_req;
  logic [2:0]      irq_vec;
  logic [NSRC-1:0] pending;
  logic            busy;
  modport master (output irq_in, mask_we, mask_in, irq_ack, eoi,
                  input irq_req, irq_vec, pending, busy);
  modport slave (input irq_in, mask_we, mask_in, irq_ack, eoi,
                 output irq_req, irq_vec, pending, busy);
endinterface

// File: rtl/prio_sel8.sv
// prio_sel8: combinational highest-set-bit selector (bit 7 wins).
module prio_sel8 (
  input  logic [7:0] req_i,
  output logic [2:0] idx_o,
  output logic       valid_o
);
  always_comb begin
    idx_o = 3'd0;
    for (int i = 0; i < 8; i++) if (req_i[i]) idx_o = 3'(i);
  end
  assign valid_o = |req_i;
endmodule

// File: rtl/intr_ctrl8.sv
// intr_ctrl8: 8-source priority interrupt controller with mask, ack/eoi handshake and no nesting.
module intr_ctrl8
  import intr_pkg::*;
#(
  parameter bit EDGE = 1'b1
) (
  input logic         clk,
  input logic         rst_n,
  intr_ctrl8_if.slave bus
);
  state_e          state_q;
  logic [NSRC-1:0] pending_q, pending_d, mask_q, hist_q, set_ev, clr, elig;
  logic [2:0]      vec_q, win;
  logic            win_v, req_q, busy_q;
  localparam logic [NSRC-1:0] ONE = NSRC'(1);
  assign set_ev    = EDGE ? bus.irq_in & ~hist_q : bus.irq_in;
  assign clr       = (state_q == REQ && bus.irq_ack) ? ONE << vec_q : '0;
  // set is applied after clear so a same-cycle new event keeps the bit pending
  assign pending_d = (pending_q & ~clr) | set_ev;
  assign elig      = pending_q & ~mask_q;
  prio_sel8 u_sel (.req_i(elig), .idx_o(win), .valid_o(win_v));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      mask_q    <= '0;
      hist_q    <= '0;
      vec_q     <= '0;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      hist_q    <= bus.irq_in;
      pending_q <= pending_d;
      if (bus.mask_we) mask_q <= bus.mask_in;
      case (state_q)
        IDLE: if (win_v) begin
          state_q <= REQ;
          vec_q   <= win;
          req_q   <= 1'b1;
          busy_q  <= 1'b1;
        end
        REQ: if (bus.irq_ack) begin
          state_q <= SERVICE;
          req_q   <= 1'b0;
        end
        SERVICE: if (bus.eoi) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end
  assign bus.irq_req = req_q;
  assign bus.irq_vec = vec_q;
  assign bus.pending = pending_q;
  assign bus.busy    = busy_q;
endmodule
